uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, N_DATA data LSB-first, optional parity, M_STOP stop bits).
// Define UART_RX_SYNC_EN to pass i_data through a 2-flop synchronizer before the FSM.
module uart_rx #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned N_DATA          = 8,
    parameter int unsigned LOG2_N_DATA     = 4,
    parameter int unsigned PARITY_CHECK    = 1,
    parameter int unsigned EVEN_ODD_PARITY = 1,
    parameter int unsigned M_STOP          = 1,
    parameter int unsigned LOG2_M_STOP     = 1,
    parameter int unsigned N_TICKS         = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_parity_err,
    output logic               o_frame_err
);
    localparam int unsigned TICK_W = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
    localparam logic [TICK_W-1:0]      TICK_MID  = TICK_W'(N_TICKS / 2 - 1);
    localparam logic [TICK_W-1:0]      TICK_END  = TICK_W'(N_TICKS - 1);
    localparam logic [LOG2_N_DATA-1:0] BIT_LAST  = LOG2_N_DATA'(N_DATA - 1);
    localparam logic [LOG2_M_STOP-1:0] STOP_LAST = LOG2_M_STOP'(M_STOP - 1);
    localparam logic                   PAR_ODD   = (EVEN_ODD_PARITY == 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [TICK_W-1:0]      tick_cnt;
    logic [LOG2_N_DATA-1:0] bit_cnt;
    logic [LOG2_M_STOP-1:0] stop_cnt;
    logic [N_DATA-1:0]      shreg;
    logic                   prev;
    logic                   par_err;
    logic                   frm_err;
    logic                   line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    // Idle-high synchronizer so reset never fakes a falling edge
    always_ff @(posedge i_clock) begin
        if (i_reset) sync <= 2'b11;
        else         sync <= {sync[0], i_data};
    end
    assign line = sync[1];
`else
    assign line = i_data;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= '0;
            shreg        <= '0;
            prev         <= 1'b1;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            o_data       <= '0;
            o_rx_done    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            if (i_valid) begin
                prev <= line;
                case (state)
                    IDLE: begin
                        // Arm only on an observed 1->0 edge; a stuck-low line never restarts
                        if (prev && !line) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= line ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            shreg    <= {line, shreg[N_DATA-1:1]};
                            bit_cnt  <= bit_cnt + LOG2_N_DATA'(1);
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt  <= '0;
                                stop_cnt <= '0;
                                par_err  <= 1'b0;
                                frm_err  <= 1'b0;
                                state    <= (PARITY_CHECK != 0) ? PARITY : STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    PARITY: begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            par_err  <= (^shreg) ^ line ^ PAR_ODD;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    STOP: begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            frm_err  <= frm_err | ~line;
                            if (stop_cnt == STOP_LAST) begin
                                // Finish at mid last stop bit so a following start edge is not missed
                                stop_cnt     <= '0;
                                state        <= IDLE;
                                o_data       <= NB_DATA'(shreg);
                                o_parity_err <= (PARITY_CHECK != 0) & par_err;
                                o_frame_err  <= frm_err | ~line;
                                o_rx_done    <= 1'b1;
                            end else begin
                                stop_cnt <= stop_cnt + LOG2_M_STOP'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx in its default 8E1, 16x configuration; i_valid ticks every other clock.
module tb_uart_rx;
    localparam int NT = 16;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic       i_data;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_parity_err;
    logic       o_frame_err;

    uart_rx dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clock = ~i_clock;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int base;
    logic [7:0] cap_data [0:63];
    logic       cap_perr [0:63];
    logic       cap_ferr [0:63];

    // Record every cycle o_rx_done is high; a stretched pulse shows up as extra counts
    always @(negedge i_clock) begin
        if (o_rx_done === 1'b1) begin
            if (done_cnt < 64) begin
                cap_data[done_cnt] = o_data;
                cap_perr[done_cnt] = o_parity_err;
                cap_ferr[done_cnt] = o_frame_err;
            end
            done_cnt++;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic b);
        @(negedge i_clock);
        i_data  = b;
        i_valid = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
    endtask

    task automatic hold(input logic b, input int n);
        repeat (n) tick(b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        hold(1'b0, NT);
        for (int i = 0; i < 8; i++) hold(d[i], NT);
        hold(par, NT);
        hold(stp, NT);
    endtask

    initial begin
        vecs[0] = '{8'hEE, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0};
        vecs[1] = '{8'h24, 1'b1, 1'b1, 8'h24, 1'b1, 1'b0};
        vecs[2] = '{8'h24, 1'b0, 1'b1, 8'h24, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 1'b1;
        repeat (3) @(negedge i_clock);
        check("reset o_data", o_data, 8'h00);
        check("reset o_rx_done", o_rx_done, 1'b0);
        check("reset o_parity_err", o_parity_err, 1'b0);
        check("reset o_frame_err", o_frame_err, 1'b0);
        i_reset = 1'b0;
        hold(1'b1, 4);

        // Single frames with idle gaps
        for (int i = 0; i < 9; i++) begin
            base = done_cnt;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stp);
            hold(1'b1, 2 * NT);
            check($sformatf("vec%0d done count", i), done_cnt - base, 1);
            check($sformatf("vec%0d o_data", i), o_data, vecs[i].exp_data);
            check($sformatf("vec%0d parity_err", i), o_parity_err, vecs[i].exp_perr);
            check($sformatf("vec%0d frame_err", i), o_frame_err, vecs[i].exp_ferr);
        end

        // Back-to-back frames, no idle between stop and next start
        base = done_cnt;
        send_frame(8'hEE, 1'b0, 1'b1);
        send_frame(8'h24, 1'b0, 1'b1);
        hold(1'b1, 2 * NT);
        check("b2b done count", done_cnt - base, 2);
        check("b2b first data", cap_data[base], 8'hEE);
        check("b2b second data", cap_data[base + 1], 8'h24);
        check("b2b first errs", {cap_perr[base], cap_ferr[base]}, 2'b00);
        check("b2b second errs", {cap_perr[base + 1], cap_ferr[base + 1]}, 2'b00);

        // Start glitch low for 4 ticks, then a real frame
        base = done_cnt;
        hold(1'b0, 4);
        hold(1'b1, 2 * NT);
        check("glitch no done", done_cnt - base, 0);
        send_frame(8'h55, 1'b0, 1'b1);
        hold(1'b1, 2 * NT);
        check("post-glitch done count", done_cnt - base, 1);
        check("post-glitch data", cap_data[base], 8'h55);
        check("post-glitch errs", {o_parity_err, o_frame_err}, 2'b00);

        // Low stop bit, then line stuck low for 3 frame times
        base = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 3 * 11 * NT);
        check("break done count", done_cnt - base, 1);
        check("break data", cap_data[base], 8'h3C);
        check("break frame_err", cap_ferr[base], 1'b1);
        check("break parity_err", cap_perr[base], 1'b0);
        hold(1'b1, 2 * NT);
        check("break release no done", done_cnt - base, 1);
        send_frame(8'h5A, 1'b0, 1'b1);
        hold(1'b1, 2 * NT);
        check("after break done count", done_cnt - base, 2);
        check("after break data", o_data, 8'h5A);
        check("after break frame_err", o_frame_err, 1'b0);

        // Reset pulse in the middle of data bit 4 of 0xEE
        base = done_cnt;
        hold(1'b0, NT);
        for (int i = 0; i < 4; i++) hold(((8'hEE >> i) & 8'h01) != 0, NT);
        hold(1'b0, NT / 2);
        @(negedge i_clock);
        i_reset = 1'b1;
        i_data  = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("midreset o_data", o_data, 8'h00);
        check("midreset o_rx_done", o_rx_done, 1'b0);
        check("midreset flags", {o_parity_err, o_frame_err}, 2'b00);
        hold(1'b1, 3 * NT);
        check("midreset no done", done_cnt - base, 0);
        send_frame(8'h24, 1'b0, 1'b1);
        hold(1'b1, 2 * NT);
        check("post-reset done count", done_cnt - base, 1);
        check("post-reset data", o_data, 8'h24);
        check("post-reset errs", {o_parity_err, o_frame_err}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
